// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing the L1 memory request channel among NrPorts requesters, with store throttling.
// Latency: a request accepted in cycle N is presented on mem_req_* in cycle N+1; returns are routed combinationally.
// Backpressure: one-entry output stage refills in the cycle it drains; stores stall at MaxOutstandingStores, all stall on drain.
module wt_mem_req_arbiter #(
  parameter int NrPorts              = 3,
  parameter int PayloadWidth         = 96,
  parameter int MaxOutstandingStores = 7
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NrPorts-1:0]                        req_valid_i,
  input  logic [NrPorts-1:0]                        req_is_store_i,
  input  logic [NrPorts*PayloadWidth-1:0]           req_payload_i,
  output logic [NrPorts-1:0]                        req_ready_o,
  output logic                                      mem_req_valid_o,
  input  logic                                      mem_req_ready_i,
  output logic [PayloadWidth-1:0]                   mem_req_payload_o,
  output logic [$clog2(NrPorts)-1:0]                mem_req_port_o,
  output logic                                      mem_req_is_store_o,
  input  logic                                      mem_rtrn_valid_i,
  input  logic [$clog2(NrPorts)-1:0]                mem_rtrn_port_i,
  input  logic                                      mem_rtrn_is_store_i,
  output logic [NrPorts-1:0]                        rtrn_valid_o,
  input  logic                                      drain_i,
  output logic                                      drain_done_o,
  output logic [$clog2(MaxOutstandingStores+1)-1:0] outstanding_stores_o,
  output logic                                      err_o
);

  localparam int PortW = $clog2(NrPorts);
  localparam int CntW  = $clog2(MaxOutstandingStores + 1);

  typedef enum logic {EMPTY, FULL} stage_e;

  stage_e             state_q, state_d;
  logic [PortW-1:0]   rr_q;
  logic [PortW-1:0]   grant_idx;
  logic [PortW-1:0]   cand_idx;
  logic               grant_vld;
  logic               accept;
  logic               store_full;
  logic               store_inc;
  logic               store_dec;
  logic [NrPorts-1:0] eligible;
  logic [CntW-1:0]    cnt_q;
  int                 cand;

  assign store_full = (cnt_q == CntW'(MaxOutstandingStores));

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NrPorts; i++) begin
      eligible[i] = req_valid_i[i] & ~drain_i & ~(req_is_store_i[i] & store_full);
    end
  end

  // Scan from the farthest offset down so the closest eligible port to rr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = NrPorts - 1; off >= 0; off--) begin
      cand = int'(rr_q) + off;
      if (cand >= NrPorts) cand = cand - NrPorts;
      cand_idx = PortW'(cand);
      if (eligible[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign accept = grant_vld & ((state_q == EMPTY) | mem_req_ready_i);

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (mem_req_ready_i && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rr_q <= (grant_idx == PortW'(NrPorts - 1)) ? '0 : grant_idx + PortW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_payload_o  <= '0;
      mem_req_port_o     <= '0;
      mem_req_is_store_o <= 1'b0;
    end else if (accept) begin
      mem_req_payload_o  <= req_payload_i[grant_idx*PayloadWidth +: PayloadWidth];
      mem_req_port_o     <= grant_idx;
      mem_req_is_store_o <= req_is_store_i[grant_idx];
    end
  end

  assign mem_req_valid_o = (state_q == FULL);

  assign store_inc = accept & req_is_store_i[grant_idx];
  assign store_dec = mem_rtrn_valid_i & mem_rtrn_is_store_i;

  // An ack with nothing outstanding is a protocol error: hold count at zero and flag it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_o <= 1'b0;
    end else begin
      if (store_dec && cnt_q == '0) err_o <= 1'b1;
      if (store_inc && !store_dec) cnt_q <= cnt_q + CntW'(1);
      else if (store_dec && !store_inc && cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign outstanding_stores_o = cnt_q;

  always_comb begin
    rtrn_valid_o = '0;
    for (int i = 0; i < NrPorts; i++) begin
      rtrn_valid_o[i] = mem_rtrn_valid_i & (mem_rtrn_port_i == PortW'(i));
    end
  end

  assign drain_done_o = drain_i & (state_q == EMPTY) & (cnt_q == '0);

endmodule
